// File: rtl/xm_mem_pkg.sv
// Shared definitions for the data-access command path: command bit indices,
// responder FSM states, reserved-encoding mask and the captured request payload.
package xm_mem_pkg;

  localparam int unsigned MC_WORD  = 16;
  localparam int unsigned MC_BYTE  = 8;
  localparam int unsigned MC_CMD_W = 3;
  localparam int unsigned MC_CNT_W = 4;

  // Bit positions inside the {RW,HB,LB} command
  typedef enum logic [1:0] {
    CMD_LB = 2'd0,
    CMD_HB = 2'd1,
    CMD_RW = 2'd2
  } cmd_bit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mc_state_t;

  // HB,LB both clear is the reserved encoding
  localparam logic [MC_CMD_W-1:0] CMD_RSVD_MASK = 3'b011;

  // Request fields latched at capture; addr[0] is dropped, only the word index is kept
  typedef struct packed {
    logic [MC_CMD_W-1:0] cmd;
    logic [MC_WORD-2:0]  idx;
    logic [MC_WORD-1:0]  wdata;
  } mc_req_t;

  function automatic logic cmd_is_rsvd(input logic [MC_CMD_W-1:0] cmd);
    return (cmd & CMD_RSVD_MASK) == '0;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: read shift/zero-extend and write merge for a two-lane word.
module mem_lane_steer
  import xm_mem_pkg::*;
(
  input  logic [1:0]         be_i,
  input  logic [MC_WORD-1:0] old_word_i,
  input  logic [MC_WORD-1:0] wdata_i,
  output logic [MC_WORD-1:0] new_word_c_o,
  output logic [MC_WORD-1:0] rd_word_c_o
);

  localparam int unsigned HI = MC_WORD - 1;
  localparam int unsigned LO = MC_BYTE;

  // Byte writes always source wdata[7:0]; a lone high-byte read is shifted down
  always_comb begin
    new_word_c_o = old_word_i;
    rd_word_c_o  = '0;
    case (be_i)
      2'b11: begin
        new_word_c_o = wdata_i;
        rd_word_c_o  = old_word_i;
      end
      2'b01: begin
        new_word_c_o = {old_word_i[HI:LO], wdata_i[LO-1:0]};
        rd_word_c_o  = {8'h00, old_word_i[LO-1:0]};
      end
      2'b10: begin
        new_word_c_o = {wdata_i[LO-1:0], old_word_i[LO-1:0]};
        rd_word_c_o  = {8'h00, old_word_i[HI:LO]};
      end
      default: begin
        new_word_c_o = old_word_i;
        rd_word_c_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/memory_controller.sv
// Data-access responder: captures a {RW,HB,LB} request, waits WAIT_STATES cycles,
// then performs a steered byte/word access on the internal RAM and pulses done_o.
module memory_controller
  import xm_mem_pkg::*;
#(
  parameter int unsigned WORD        = MC_WORD,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_i,
  input  logic [2:0]      cmd_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic            done_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [MC_CNT_W-1:0] WS_LOAD = MC_CNT_W'(WAIT_STATES);
  localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

  mc_state_t             state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
  mc_req_t               req_q, req_d;
  logic [WORD-1:0]       rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [WORD-1:0]       ram_q [DEPTH_WORDS];
  logic [AW-1:0]         ram_addr_c;
  logic [WORD-1:0]       old_word_c;
  logic [WORD-1:0]       new_word_c;
  logic [WORD-1:0]       rd_word_c;
  logic                  in_range_c;
  logic                  acc_err_c;
  logic                  ram_we_c;
  logic                  unused_addr_lsb;

  // Byte-address LSB never alters the word index
  assign unused_addr_lsb = addr_i[0];

  // Access qualification from the captured request
  assign in_range_c = 32'(req_q.idx) < DEPTH_WORDS;
  assign acc_err_c  = cmd_is_rsvd(req_q.cmd) || !in_range_c;
  assign ram_addr_c = req_q.idx[AW-1:0];
  assign old_word_c = ram_q[ram_addr_c];

  mem_lane_steer u_steer (
    .be_i         (req_q.cmd[1:0]),
    .old_word_i   (old_word_c),
    .wdata_i      (req_q.wdata),
    .new_word_c_o (new_word_c),
    .rd_word_c_o  (rd_word_c)
  );

  // Next-state, capture and response decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    ram_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          req_d.cmd   = cmd_i;
          req_d.idx   = addr_i[WORD-1:1];
          req_d.wdata = wdata_i;
          cnt_d       = WS_LOAD;
          busy_d      = 1'b1;
          state_d     = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        err_d   = acc_err_c;
        state_d = IDLE;
        if (acc_err_c) begin
          rdata_d = '0;
        end else if (!req_q.cmd[CMD_RW]) begin
          rdata_d = rd_word_c;
        end else begin
          ram_we_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any access in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // RAM write port; contents survive reset, writes land only on the RESP edge
  always_ff @(posedge clk_i) begin
    if (ram_we_c) begin
      ram_q[ram_addr_c] <= new_word_c;
    end
  end

  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: WAIT_STATES=1 main instance plus a WAIT_STATES=0 instance.
module tb_memory_controller;

  localparam int TMO = 20;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i, req0_i;
  logic [2:0]  cmd_i, cmd0_i;
  logic [15:0] addr_i, addr0_i, wdata_i, wdata0_i;
  logic [15:0] rdata_o, rdata0_o;
  logic        done_o, done0_o, err_o, err0_o, busy_o, busy0_o;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb_q[$];

  always #5 clk_i = ~clk_i;

  memory_controller #(.WORD(16), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .cmd_i(cmd_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  memory_controller #(.WORD(16), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req0_i), .cmd_i(cmd0_i), .addr_i(addr0_i),
    .wdata_i(wdata0_i), .rdata_o(rdata0_o), .done_o(done0_o), .err_o(err0_o), .busy_o(busy0_o)
  );

  // Drive one request on the main instance and wait (bounded) for its done pulse
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                       output bit ok, output int lat, output logic e, output logic [15:0] r);
    cmd_i = c; addr_i = a; wdata_i = d; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0; cmd_i = 3'($urandom); addr_i = 16'($urandom); wdata_i = 16'($urandom);
    ok = 1'b0; lat = 0; e = 1'b0; r = '0;
    for (int k = 1; k <= TMO; k++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        ok = 1'b1; lat = k; e = err_o; r = rdata_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; req_i = 1'b0; cmd_i = '0; addr_i = '0; wdata_i = '0;
    req0_i = 1'b0; cmd0_i = '0; addr0_i = '0; wdata0_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      n_vec++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset[%0d]: done=%b busy=%b err=%b rdata=%h, required 0 0 0 0000",
                 i, done_o, busy_o, err_o, rdata_o);
      end
    end
  endtask

  task automatic test_word();
    vec_t tbl [4];
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    tbl = '{'{3'b111, 16'h0010, 16'hBEEF, 16'h0000, 1'b0},
            '{3'b011, 16'h0010, 16'h0000, 16'hBEEF, 1'b0},
            '{3'b111, 16'h0000, 16'h1111, 16'hBEEF, 1'b0},
            '{3'b011, 16'h0000, 16'h0000, 16'h1111, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(tbl[i]);
      issue(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, ok, lat, e, r);
      ev = sb_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL word[%0d]: no done_o within %0d cycles", i, TMO);
      end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
        n_bad++;
        $display("FAIL word[%0d]: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                 i, lat, e, r, ev.err, ev.rdata);
      end
    end
  endtask

  task automatic test_byte_lanes();
    vec_t tbl [4];
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    tbl = '{'{3'b110, 16'h0011, 16'h00A5, 16'h1111, 1'b0},
            '{3'b010, 16'h0011, 16'h0000, 16'h00A5, 1'b0},
            '{3'b001, 16'h0010, 16'h0000, 16'h00EF, 1'b0},
            '{3'b011, 16'h0011, 16'h0000, 16'hA5EF, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(tbl[i]);
      issue(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, ok, lat, e, r);
      ev = sb_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL lanes[%0d]: no done_o within %0d cycles", i, TMO);
      end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
        n_bad++;
        $display("FAIL lanes[%0d]: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                 i, lat, e, r, ev.err, ev.rdata);
      end
    end
  endtask

  task automatic test_errors();
    vec_t tbl [7];
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    tbl = '{'{3'b100, 16'h0010, 16'hFFFF, 16'h0000, 1'b1},
            '{3'b011, 16'h0010, 16'h0000, 16'hA5EF, 1'b0},
            '{3'b000, 16'h0010, 16'h0000, 16'h0000, 1'b1},
            '{3'b011, 16'h0800, 16'h0000, 16'h0000, 1'b1},
            '{3'b111, 16'h0800, 16'hDEAD, 16'h0000, 1'b1},
            '{3'b011, 16'h0000, 16'h0000, 16'h1111, 1'b0},
            '{3'b011, 16'hFFFE, 16'h0000, 16'h0000, 1'b1}};
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(tbl[i]);
      issue(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, ok, lat, e, r);
      ev = sb_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL errors[%0d]: no done_o within %0d cycles", i, TMO);
      end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
        n_bad++;
        $display("FAIL errors[%0d]: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                 i, lat, e, r, ev.err, ev.rdata);
      end
    end
  endtask

  task automatic test_lane_merge();
    vec_t tbl [3];
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    tbl = '{'{3'b101, 16'h0010, 16'h5A34, 16'h0000, 1'b0},
            '{3'b011, 16'h0010, 16'h0000, 16'hA534, 1'b0},
            '{3'b010, 16'h0010, 16'h0000, 16'h00A5, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(tbl[i]);
      issue(tbl[i].cmd, tbl[i].addr, tbl[i].wdata, ok, lat, e, r);
      ev = sb_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL merge[%0d]: no done_o within %0d cycles", i, TMO);
      end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
        n_bad++;
        $display("FAIL merge[%0d]: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                 i, lat, e, r, ev.err, ev.rdata);
      end
    end
  endtask

  // req_i held high: captures at k=0,3,6, done at k=2,5,8
  task automatic test_back_to_back();
    vec_t ev;
    logic exp_done;
    cmd_i = 3'b011; addr_i = 16'h0010; wdata_i = '0; req_i = 1'b1;
    sb_q.push_back('{3'b011, 16'h0010, 16'h0000, 16'hA534, 1'b0});
    @(posedge clk_i); #1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk_i); #1;
      exp_done = (k % 3 == 2) && (k < 9);
      n_vec++;
      if (done_o !== exp_done || busy_o !== (k < 9)) begin
        n_bad++;
        $display("FAIL b2b[%0d]: done=%b busy=%b, required done=%b busy=%b",
                 k, done_o, busy_o, exp_done, (k < 9));
      end
      if (done_o === 1'b1 && sb_q.size() > 0) begin
        ev = sb_q.pop_front();
        n_vec++;
        if (rdata_o !== ev.rdata || err_o !== ev.err) begin
          n_bad++;
          $display("FAIL b2b_data[%0d]: rdata=%h err=%b, required rdata=%h err=%b",
                   k, rdata_o, err_o, ev.rdata, ev.err);
        end
      end
      if (k == 3 || k == 6) sb_q.push_back('{3'b011, 16'h0010, 16'h0000, 16'hA534, 1'b0});
      if (k == 8) req_i = 1'b0;
    end
    sb_q.delete();
  endtask

  // Reset asserted in WAIT (depth 1) and in RESP (depth 2) must drop the write silently
  task automatic test_reset_mid();
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    logic [15:0] wd [2];
    wd[0] = 16'h1234; wd[1] = 16'h7777;
    for (int j = 0; j < 2; j++) begin
      cmd_i = 3'b111; addr_i = 16'h0010; wdata_i = wd[j]; req_i = 1'b1;
      @(posedge clk_i); #1;
      req_i = 1'b0;
      if (j == 1) begin
        @(posedge clk_i); #1;
      end
      rst_n_i = 1'b0; #2;
      n_vec++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== 16'h0000) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: done=%b busy=%b rdata=%h, required 0 0 0000",
                 j, done_o, busy_o, rdata_o);
      end
      for (int k = 0; k < 3; k++) begin
        @(posedge clk_i); #1;
        n_vec++;
        if (done_o !== 1'b0) begin
          n_bad++; $display("FAIL rst_hold[%0d.%0d]: done=%b, required 0", j, k, done_o);
        end
      end
      @(negedge clk_i); rst_n_i = 1'b1;
      @(posedge clk_i); #1;
    end
    sb_q.push_back('{3'b011, 16'h0010, 16'h0000, 16'hA534, 1'b0});
    issue(3'b011, 16'h0010, 16'h0000, ok, lat, e, r);
    ev = sb_q.pop_front();
    n_vec++;
    if (!ok) begin
      n_bad++; $display("FAIL rst_readback: no done_o within %0d cycles", TMO);
    end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
      n_bad++;
      $display("FAIL rst_readback: lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
               lat, e, r, ev.err, ev.rdata);
    end
  endtask

  // Random word write/read pairs checked against a sparse memory model
  task automatic test_random();
    logic [15:0] model [int];
    logic [15:0] last_rd = 16'hA534;
    logic [15:0] a, d;
    vec_t ev;
    bit ok; int lat; logic e; logic [15:0] r;
    for (int i = 0; i < 12; i++) begin
      a = 16'(2 * $urandom_range(256, 511));
      if (i % 2 == 0) begin
        d = 16'($urandom);
        model[int'(a)] = d;
        sb_q.push_back('{3'b111, a, d, last_rd, 1'b0});
        issue(3'b111, a, d, ok, lat, e, r);
      end else begin
        a = 16'h0000;
        foreach (model[key]) a = 16'(key);
        last_rd = model[int'(a)];
        sb_q.push_back('{3'b011, a, 16'h0000, last_rd, 1'b0});
        issue(3'b011, a | 16'h0001, 16'h0000, ok, lat, e, r);
      end
      ev = sb_q.pop_front();
      n_vec++;
      if (!ok) begin
        n_bad++; $display("FAIL rand[%0d]: no done_o within %0d cycles", i, TMO);
      end else if (lat !== 2 || e !== ev.err || r !== ev.rdata) begin
        n_bad++;
        $display("FAIL rand[%0d]: addr=%h lat=%0d err=%b rdata=%h, required lat=2 err=%b rdata=%h",
                 i, ev.addr, lat, e, r, ev.err, ev.rdata);
      end
    end
  endtask

  // Zero-wait-state instance: done one cycle after capture, busy for two cycles
  task automatic test_ws0();
    vec_t tbl [2];
    vec_t ev;
    tbl = '{'{3'b111, 16'h0020, 16'hCAFE, 16'h0000, 1'b0},
            '{3'b011, 16'h0020, 16'h0000, 16'hCAFE, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      cmd0_i = tbl[i].cmd; addr0_i = tbl[i].addr; wdata0_i = tbl[i].wdata; req0_i = 1'b1;
      sb_q.push_back(tbl[i]);
      @(posedge clk_i); #1;
      req0_i = 1'b0; cmd0_i = 3'($urandom); addr0_i = 16'($urandom); wdata0_i = 16'($urandom);
      n_vec++;
      if (done0_o !== 1'b0 || busy0_o !== 1'b1) begin
        n_bad++; $display("FAIL ws0_cap[%0d]: done=%b busy=%b, required 0 1", i, done0_o, busy0_o);
      end
      @(posedge clk_i); #1;
      ev = sb_q.pop_front();
      n_vec++;
      if (done0_o !== 1'b1 || busy0_o !== 1'b1 || err0_o !== ev.err || rdata0_o !== ev.rdata) begin
        n_bad++;
        $display("FAIL ws0_done[%0d]: done=%b busy=%b err=%b rdata=%h, required 1 1 %b %h",
                 i, done0_o, busy0_o, err0_o, rdata0_o, ev.err, ev.rdata);
      end
      @(posedge clk_i); #1;
      n_vec++;
      if (done0_o !== 1'b0 || busy0_o !== 1'b0) begin
        n_bad++; $display("FAIL ws0_idle[%0d]: done=%b busy=%b, required 0 0", i, done0_o, busy0_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_lane_merge();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_ws0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
